// File: rtl/if_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: RV32 opcodes, fetch FSM
// states, queue entry layout and the J-type immediate helper.
package if_queue_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] IQ_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } iq_entry_t;

  function automatic logic [31:0] j_imm(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_decode.sv
// Combinational RV32 field decode of the queue head for the ROB.
// Unknown opcodes pass their raw register fields through with a zero immediate.
module if_decode
  import if_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [16:0] opcode_if,
  output logic [4:0]  rd_if,
  output logic [4:0]  rs1_if,
  output logic [4:0]  rs2_if,
  output logic [31:0] imm_if
);

  logic [6:0] opc;
  logic [2:0] funct3;

  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    opcode_if = {instr[31:25], instr[14:12], instr[6:0]};
    rd_if     = instr[11:7];
    rs1_if    = instr[19:15];
    rs2_if    = instr[24:20];
    imm_if    = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        rs1_if = '0;
        rs2_if = '0;
        imm_if = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        rs1_if = '0;
        rs2_if = '0;
        imm_if = j_imm(instr);
      end
      OPC_JALR, OPC_LOAD: begin
        rs2_if = '0;
        imm_if = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OPIMM: begin
        rs2_if = '0;
        // shift-immediates carry a 5-bit shamt; funct7 stays visible in opcode_if
        if (funct3 == 3'b001 || funct3 == 3'b101)
          imm_if = {27'b0, instr[24:20]};
        else
          imm_if = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        rd_if  = '0;
        imm_if = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        rd_if  = '0;
        imm_if = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_OP: imm_if = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/if_queue.sv
// Instruction fetch + circular instruction queue feeding the ROB, with commit flush.
// Optional IF_JAL_PREDICT_EN: redirect the fetch PC to the JAL target on a JAL ack.
module if_queue
  import if_queue_pkg::*;
#(
  parameter int          IQ_DEPTH  = 8,
  parameter int          IQ_ADDR_W = 3,
  parameter logic [31:0] RESET_PC  = IQ_RESET_PC
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_data_in,
  input  logic        rob_full,
  output logic        have_input,
  output logic [31:0] instr_input,
  output logic [31:0] instr_input_pc,
  output logic [16:0] opcode_if,
  output logic [4:0]  rd_if,
  output logic [4:0]  rs1_if,
  output logic [4:0]  rs2_if,
  output logic [31:0] imm_if,
  input  logic        if_pc_change_commit,
  input  logic [31:0] new_pc_address_commit
);

  localparam logic [IQ_ADDR_W:0] FULL_CNT = (IQ_ADDR_W+1)'(IQ_DEPTH);

  iq_entry_t            q_mem [IQ_DEPTH];
  iq_entry_t            head_e;
  logic [IQ_ADDR_W-1:0] head, tail;
  logic [IQ_ADDR_W:0]   count;
  logic [31:0]          pc, pc_next;
  fetch_state_e         state, state_nxt;
  logic                 flush, ack, push, pop, issue;

  assign flush = rdy_in && if_pc_change_commit;
  assign ack   = rdy_in && mem_ack_in;
  // a flushed ack is dropped; DISCARD acks never enter the queue
  assign push  = ack && !flush && (state == FS_WAIT);
  assign issue = rdy_in && (state == FS_IDLE) && !if_pc_change_commit && (count < FULL_CNT);

  assign have_input = (count != '0) && !if_pc_change_commit && rdy_in;
  assign pop        = have_input && !rob_full;

`ifdef IF_JAL_PREDICT_EN
  assign pc_next = (mem_data_in[6:0] == OPC_JAL) ? pc + j_imm(mem_data_in) : pc + 32'd4;
`else
  assign pc_next = pc + 32'd4;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= FS_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rdy_in) begin
      case (state)
        FS_IDLE:    if (issue) state_nxt = FS_WAIT;
        FS_WAIT: begin
          if (mem_ack_in)               state_nxt = FS_IDLE;
          else if (if_pc_change_commit) state_nxt = FS_DISCARD;
        end
        FS_DISCARD: if (mem_ack_in) state_nxt = FS_IDLE;
        default:    state_nxt = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc           <= RESET_PC;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      mem_req_out  <= 1'b0;
      mem_addr_out <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        pc    <= new_pc_address_commit;
      end else begin
        if (push) begin
          tail <= tail + 1'b1;
          pc   <= pc_next;
        end
        if (pop) head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
      // request stays up across a flush until the outstanding ack returns
      if (issue) begin
        mem_req_out  <= 1'b1;
        mem_addr_out <= {pc[31:2], 2'b00};
      end else if (ack && state != FS_IDLE) begin
        mem_req_out  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) q_mem[tail] <= '{instr: mem_data_in, pc: pc};
  end

  assign head_e         = q_mem[head];
  assign instr_input    = head_e.instr;
  assign instr_input_pc = head_e.pc;

  if_decode u_decode (
    .instr     (head_e.instr),
    .opcode_if (opcode_if),
    .rd_if     (rd_if),
    .rs1_if    (rs1_if),
    .rs2_if    (rs2_if),
    .imm_if    (imm_if)
  );

endmodule

// File: tb/tb_if_queue.sv
// Randomized scoreboard bench for if_queue: a memory model feeds fetches, a
// transaction-level model predicts the popped stream, a monitor compares.
module tb_if_queue;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic        mem_ack_in = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic        rob_full = 1'b0;
  logic        if_pc_change_commit = 1'b0;
  logic [31:0] new_pc_address_commit = '0;
  logic        mem_req_out, have_input;
  logic [31:0] mem_addr_out, instr_input, instr_input_pc, imm_if;
  logic [16:0] opcode_if;
  logic [4:0]  rd_if, rs1_if, rs2_if;

  always #5 clk_in = ~clk_in;

  if_queue dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .mem_req_out           (mem_req_out),
    .mem_addr_out          (mem_addr_out),
    .mem_ack_in            (mem_ack_in),
    .mem_data_in           (mem_data_in),
    .rob_full              (rob_full),
    .have_input            (have_input),
    .instr_input           (instr_input),
    .instr_input_pc        (instr_input_pc),
    .opcode_if             (opcode_if),
    .rd_if                 (rd_if),
    .rs1_if                (rs1_if),
    .rs2_if                (rs2_if),
    .imm_if                (imm_if),
    .if_pc_change_commit   (if_pc_change_commit),
    .new_pc_address_commit (new_pc_address_commit)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0, n_err = 0, n_pop = 0;
  logic        running = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    logic [31:0] sign = 32'd1 << (w - 1);
    logic [31:0] mask = (32'd1 << w) - 32'd1;
    return ((v & mask) ^ sign) - sign;
  endfunction

  function automatic logic [31:0] j_off(input logic [31:0] i);
    return sext(32'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a, input logic [31:0] w);
`ifdef IF_JAL_PREDICT_EN
    if (w[6:0] == 7'h6F) return a + j_off(w);
`endif
    return a + 32'd4;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
    logic [31:0] r = $urandom;
    logic [31:0] w = {r[31:7], ops[$urandom_range(0, 9)]};
    if (w[6:0] == 7'h6F) w[21] = 1'b0;  // keep jump targets word-aligned
    return w;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = gen_instr();
    return mem[a];
  endfunction

  // Expected decode straight from the RV32 field rules
  task automatic ref_dec(input logic [31:0] i, output logic [16:0] opc, output logic [4:0] rd,
                         output logic [4:0] rs1, output logic [4:0] rs2, output logic [31:0] imm);
    logic [6:0] op = i[6:0];
    opc = {i[31:25], i[14:12], op};
    rd = i[11:7]; rs1 = i[19:15]; rs2 = i[24:20]; imm = '0;
    if (op == 7'h37 || op == 7'h17) begin
      rs1 = '0; rs2 = '0; imm = i & 32'hFFFF_F000;
    end else if (op == 7'h6F) begin
      rs1 = '0; rs2 = '0; imm = j_off(i);
    end else if (op == 7'h67 || op == 7'h03) begin
      rs2 = '0; imm = sext(i >> 20, 12);
    end else if (op == 7'h13) begin
      rs2 = '0; imm = (i[13:12] == 2'b01) ? ((i >> 20) & 32'd31) : sext(i >> 20, 12);
    end else if (op == 7'h23) begin
      rd = '0; imm = sext(32'({i[31:25], i[11:7]}), 12);
    end else if (op == 7'h63) begin
      rd = '0; imm = sext(32'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
    end
  endtask

  // Monitor: compares the head whenever the DUT is expected to present/pop
  always @(negedge clk_in) begin
    if (running) begin
      logic        exp_have;
      ent_t        e;
      logic [16:0] eo;
      logic [4:0]  erd, ers1, ers2;
      logic [31:0] eimm;
      exp_have = (exp_q.size() != 0) && !if_pc_change_commit && rdy_in;
      chk("have_input", 32'(have_input), 32'(exp_have));
      if (exp_have && !rob_full) begin
        e = exp_q.pop_front();
        n_pop++;
        ref_dec(e.instr, eo, erd, ers1, ers2, eimm);
        chk("instr", instr_input, e.instr);
        chk("instr_pc", instr_input_pc, e.pc);
        chk("opcode", 32'(opcode_if), 32'(eo));
        chk("rd", 32'(rd_if), 32'(erd));
        chk("rs1", 32'(rs1_if), 32'(ers1));
        chk("rs2", 32'(rs2_if), 32'(ers2));
        chk("imm", imm_if, eimm);
        if (e.instr == 32'h0050_0093) begin
          chk("addi_opc", 32'(opcode_if), 32'h13);
          chk("addi_rd", 32'(rd_if), 32'd1);
          chk("addi_imm", imm_if, 32'd5);
        end
        if (e.instr == 32'h0020_A423) begin
          chk("sw_rd", 32'(rd_if), 32'd0);
          chk("sw_rs1", 32'(rs1_if), 32'd1);
          chk("sw_rs2", 32'(rs2_if), 32'd2);
          chk("sw_imm", imm_if, 32'd8);
        end
        if (e.instr == 32'hFE00_0EE3) chk("beq_imm", imm_if, 32'hFFFF_FFFC);
      end
    end
  end

  // Stimulus: memory model, flushes, back-pressure; pushes expectations
  initial begin
    logic        req_active = 1'b0, drop = 1'b0, pend_v = 1'b0, hold;
    logic [31:0] req_addr = '0, exp_fetch_pc = '0;
    ent_t        pend = '0;
    int          lat = 0;

    mem[32'd0]  = 32'h0050_0093;  // addi x1,x0,5
    mem[32'd4]  = 32'h0020_A423;  // sw x2,8(x1)
    mem[32'd8]  = 32'hFE00_0EE3;  // beq x0,x0,-4
    mem[32'd12] = 32'h0100_006F;  // jal x0,16

    #2 rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_req", 32'(mem_req_out), 32'd0);
    chk("rst_addr", mem_addr_out, 32'd0);
    chk("rst_have", 32'(have_input), 32'd0);
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    rob_full = 1'b1;
    running  = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_in);
      #1;
      if (pend_v) begin
        exp_q.push_back(pend);
        pend_v = 1'b0;
      end
      if (c == 60) begin
        chk("full_no_req", 32'(mem_req_out), 32'd0);
        chk("full_have", 32'(have_input), 32'd1);
      end
      hold                = (c < 60);
      mem_ack_in          = 1'b0;
      if_pc_change_commit = 1'b0;
      rdy_in   = hold ? 1'b1 : ($urandom_range(0, 9) != 0);
      rob_full = hold ? 1'b1 : ($urandom_range(0, 9) < 3);

      if (mem_req_out && !req_active) begin
        req_active = 1'b1;
        req_addr   = mem_addr_out;
        lat        = hold ? 2 : int'($urandom_range(0, 3));
        chk("fetch_addr", mem_addr_out, exp_fetch_pc);
      end
      if (req_active && rdy_in) begin
        if (lat == 0) begin
          mem_ack_in  = 1'b1;
          mem_data_in = fetch_word(req_addr);
        end else begin
          lat--;
        end
      end
      if (!hold && rdy_in && $urandom_range(0, 24) == 0) begin
        if_pc_change_commit   = 1'b1;
        new_pc_address_commit = ($urandom_range(0, 3) == 0) ? 32'h100 : (32'($urandom_range(0, 127)) << 2);
      end

      if (mem_ack_in) begin
        if (!if_pc_change_commit && !drop) begin
          pend         = {mem_data_in, req_addr};
          pend_v       = 1'b1;
          exp_fetch_pc = next_pc(req_addr, mem_data_in);
        end
        drop       = 1'b0;
        req_active = 1'b0;
      end
      if (if_pc_change_commit) begin
        exp_q.delete();
        exp_fetch_pc = new_pc_address_commit;
        if (req_active) drop = 1'b1;
      end
    end

    @(posedge clk_in);
    #1;
    running = 1'b0;
    chk("progress", 32'(n_pop > 100), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
